// File: rtl/dcache_fill_fsm.sv
// dcache_fill_fsm
//   Data-cache miss handler sitting between the MEM stage and the multi-cycle
//   unified main memory. On a miss it stalls the pipeline, issues WORDS
//   back-to-back word reads for the aligned block, writes every returned word
//   into the cache data array and writes the tag together with the last word.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   miss_detected     MEM-stage miss (level), accepted only while idle
//   miss_address      byte address of the missing access
//   mem_data_valid    memory returns mem_data this cycle
//   mem_data          returned word
//   fsm_busy          pipeline stall request (decode of the FILL state)
//   mem_read_en       one read request this cycle, at memory_address
//   memory_address    read request address (0 when no request)
//   write_data_array  write fill_data into slot fill_word_offset
//   fill_word_offset  word slot being written
//   fill_data         word being written (mem_data passthrough)
//   write_tag_array   write tag/valid for the block
//   critical_ready    (DCACHE_CRITICAL_FIRST_EN only) one-cycle pulse with the
//                     first returned word, which is the word that missed
//   fsm_state         current FSM state for observation (0 IDLE, 1 FILL)
//
// Handshake: a request is issued on every cycle mem_read_en=1 (memory has no
// ready; it must accept it). A word is consumed on every cycle mem_data_valid=1
// while filling; valids outside a fill are dropped.
//
// Optional feature macro: DCACHE_CRITICAL_FIRST_EN -- request and fill order
// start at the missing word and wrap within the block.
module dcache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8,
  parameter int OFF_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_data_valid,
  input  logic [ADDR_W-1:0] mem_data,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [OFF_W-1:0]  fill_word_offset,
  output logic [ADDR_W-1:0] fill_data,
  output logic              write_tag_array,
`ifdef DCACHE_CRITICAL_FIRST_EN
  output logic              critical_ready,
`endif
  output logic              fsm_state
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [OFF_W:0]   REQ_DONE  = (OFF_W + 1)'(WORDS);
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  state_t              state_q, state_d;
  logic [OFF_W:0]      req_cnt;   // one extra bit so it can park at WORDS
  logic [OFF_W-1:0]    rcv_cnt;
  logic [ADDR_W-1:0]   base;
  logic [OFF_W-1:0]    req_off, rcv_off;
  logic                last_word;

  // Bit 0 selects a byte inside a word; a whole-block fill never needs it.
  logic unused_addr_bits;

`ifdef DCACHE_CRITICAL_FIRST_EN
  logic [OFF_W-1:0] crit_off;

  always_ff @(posedge clk) begin
    if (rst)
      crit_off <= '0;
    else if (state_q == IDLE && miss_detected)
      crit_off <= miss_address[OFF_W:1];
  end

  // Truncation to OFF_W bits gives the wrap within the block.
  assign req_off = crit_off + req_cnt[OFF_W-1:0];
  assign rcv_off = crit_off + rcv_cnt;
  assign unused_addr_bits = miss_address[0];
`else
  assign req_off = req_cnt[OFF_W-1:0];
  assign rcv_off = rcv_cnt;
  assign unused_addr_bits = ^miss_address[OFF_W:0];
`endif

  assign last_word = (rcv_cnt == LAST_WORD);
  assign fsm_state = state_q;

  // State register and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_cnt <= '0;
      rcv_cnt <= '0;
      base    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (miss_detected) begin
            base    <= {miss_address[ADDR_W-1:OFF_W+1], {(OFF_W + 1){1'b0}}};
            req_cnt <= '0;
            rcv_cnt <= '0;
          end
        end
        FILL: begin
          if (req_cnt < REQ_DONE)
            req_cnt <= req_cnt + 1'b1;
          if (mem_data_valid) begin
            if (last_word) begin
              // Block complete: clear so the next fill starts from zero.
              req_cnt <= '0;
              rcv_cnt <= '0;
            end else begin
              rcv_cnt <= rcv_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and outputs
  always_comb begin
    state_d          = state_q;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word_offset = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;
`ifdef DCACHE_CRITICAL_FIRST_EN
    critical_ready   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (miss_detected)
          state_d = FILL;
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (req_cnt < REQ_DONE) begin
          mem_read_en    = 1'b1;
          // base is block aligned, so this never carries out of the block.
          memory_address = base + {{(ADDR_W - OFF_W - 1){1'b0}}, req_off, 1'b0};
        end
        if (mem_data_valid) begin
          write_data_array = 1'b1;
          fill_word_offset = rcv_off;
          fill_data        = mem_data;
`ifdef DCACHE_CRITICAL_FIRST_EN
          critical_ready   = (rcv_cnt == '0);
`endif
          if (last_word) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
